// File: rtl/npc_bus_pkg.sv
// Shared definitions for the npc memory-port arbiter: bus widths, master IDs,
// FSM state encoding and a small grant-vector helper.
package npc_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Master identifiers, also used as the stored last_grant / owner value
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  // Arbiter FSM states {IDLE, REQ, WAIT}
  typedef logic [1:0] npc_state_t;
  localparam npc_state_t ST_IDLE = 2'd0;
  localparam npc_state_t ST_REQ  = 2'd1;
  localparam npc_state_t ST_WAIT = 2'd2;

  // Convert a master id into its one-hot grant vector (bit0 = IFU, bit1 = LSU)
  function automatic logic [1:0] id_to_onehot(input logic id);
    logic [1:0] oh;
    if (id == MST_LSU) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the caller stores the
// previous winner and feeds it back on last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       id
);
  import npc_bus_pkg::*;

  // Pick the sole requester, or on a tie the master that did not win last
  always_comb begin
    id    = MST_IFU;
    grant = 2'b00;
    case (req)
      2'b01:   id = MST_IFU;
      2'b10:   id = MST_LSU;
      2'b11:   id = ~last;
      default: id = MST_IFU;
    endcase
    if (req != 2'b00) begin
      grant = id_to_onehot(id);
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/npc_mem_arb.sv
// Shares one memory port between the IFU and LSU. One transaction is
// outstanding at a time; the response is steered back to the master that
// owns it. Request fields are latched at grant and held until the response.
module npc_mem_arb
  import npc_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  npc_state_t state;
  logic       owner;
  logic       last_grant;
  logic [1:0] grant;
  logic       grant_id;
  logic       accept;
  logic       resp_fire;

  rr_arb2 u_rr_arb2 (
    .req   ({lsu_req_valid, ifu_req_valid}),
    .last  (last_grant),
    .grant (grant),
    .id    (grant_id)
  );

  // Read data is a straight passthrough; resp_valid qualifies it
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

  // Accept a request only while idle and out of reset; ready is same-cycle
  always_comb begin
    accept = 1'b0;
    if (!rst && (state == ST_IDLE) && (grant != 2'b00)) begin
      accept = 1'b1;
    end else begin
      accept = 1'b0;
    end
    ifu_req_ready = accept & grant[0];
    lsu_req_ready = accept & grant[1];
  end

  // Drive the memory request and route the response to its owner; reset
  // masks both so an in-flight response is discarded
  always_comb begin
    mem_req_valid = 1'b0;
    resp_fire     = 1'b0;
    if (!rst && (state == ST_REQ)) begin
      mem_req_valid = 1'b1;
    end else begin
      mem_req_valid = 1'b0;
    end
    if (!rst && (state == ST_WAIT) && mem_resp_valid) begin
      resp_fire = 1'b1;
    end else begin
      resp_fire = 1'b0;
    end
    ifu_resp_valid = resp_fire & (owner == MST_IFU);
    lsu_resp_valid = resp_fire & (owner == MST_LSU);
  end

  // FSM, owner/last-grant tracking and the request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= MST_LSU;
      last_grant <= MST_LSU;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_REQ;
            owner      <= grant_id;
            last_grant <= grant_id;
            if (grant_id == MST_LSU) begin
              mem_addr  <= lsu_addr;
              mem_wen   <= lsu_wen;
              mem_wdata <= lsu_wdata;
              mem_wmask <= lsu_wmask;
            end else begin
              // Fetches are always reads with no byte enables
              mem_addr  <= ifu_addr;
              mem_wen   <= 1'b0;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mem_arb.sv
// Bench for npc_mem_arb: directed scenarios first, then randomized traffic
// checked by a scoreboard against a transaction-level reference model.
module tb_npc_mem_arb;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  npc_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Step to just after the next active edge, where inputs are driven
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    bit          who;   // 0 = IFU, 1 = LSU
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] data;  // expected read data (loads/fetches)
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  int          m_phase;      // 0 idle, 1 request issued, 2 awaiting response
  bit          m_last;       // previous winner
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] dev_mem   [logic [31:0]];

  bit          auto_en = 1'b0;
  bit          gen_new = 1'b0;
  bit          acc_ifu, acc_lsu, hs_seen;
  bit          hs_wen;
  logic [31:0] hs_addr, hs_wdata;
  logic [3:0]  hs_wmask;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 + (32'($urandom_range(0, 7)) << 2);
  endfunction

  // ---------------- randomized requesters ----------------
  initial begin
    forever begin
      cyc();
      if (auto_en) begin
        if (acc_ifu) begin acc_ifu = 1'b0; ifu_req_valid = 1'b0; end
        if (acc_lsu) begin acc_lsu = 1'b0; lsu_req_valid = 1'b0; end
        if (gen_new && !ifu_req_valid && ($urandom_range(0, 2) == 0)) begin
          ifu_req_valid = 1'b1;
          ifu_addr      = rand_addr();
        end
        if (gen_new && !lsu_req_valid && ($urandom_range(0, 2) == 0)) begin
          lsu_req_valid = 1'b1;
          lsu_addr      = rand_addr();
          lsu_wen       = 1'($urandom_range(0, 1));
          lsu_wdata     = $urandom;
          lsu_wmask     = 4'($urandom_range(0, 15));
        end
      end
    end
  end

  // ---------------- randomized memory device ----------------
  initial begin
    bit pending;
    bit resp_real;
    int delay;
    pending = 1'b0; resp_real = 1'b0; delay = 0;
    forever begin
      cyc();
      if (!auto_en) begin
        pending = 1'b0; resp_real = 1'b0;
      end else begin
        if (mem_resp_valid && resp_real) pending = 1'b0;
        mem_resp_valid = 1'b0;
        resp_real      = 1'b0;
        if (hs_seen) begin
          hs_seen = 1'b0;
          pending = 1'b1;
          delay   = $urandom_range(0, 2);
          if (hs_wen) dev_mem[hs_addr] = merge(dev_rd(hs_addr), hs_wdata, hs_wmask);
        end else if (pending && delay > 0) begin
          delay--;
        end
        if (pending && delay == 0) begin
          mem_resp_valid = 1'b1;
          resp_real      = 1'b1;
          mem_rdata      = hs_wen ? $urandom : dev_rd(hs_addr);
        end else if (!pending && ($urandom_range(0, 7) == 0)) begin
          // stray response while nothing is outstanding: must be dropped
          mem_resp_valid = 1'b1;
          mem_rdata      = $urandom;
        end
        mem_req_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit exp_acc, exp_who, exp_resp;
    txn_t e;
    forever begin
      @(negedge clk);
      #2;
      if (auto_en && !rst) begin
        exp_acc = (m_phase == 0) && (ifu_req_valid || lsu_req_valid);
        exp_who = (ifu_req_valid && lsu_req_valid) ? ~m_last : lsu_req_valid;
        chk("ifu_req_ready", 64'(ifu_req_ready), 64'(exp_acc && !exp_who));
        chk("lsu_req_ready", 64'(lsu_req_ready), 64'(exp_acc && exp_who));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(m_phase == 1));
        if (m_phase == 1) begin
          chk("mem_addr",  64'(mem_addr),  64'(cur.addr));
          chk("mem_wen",   64'(mem_wen),   64'(cur.wen));
          chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
          chk("mem_wmask", 64'(mem_wmask), 64'(cur.wmask));
        end
        exp_resp = (m_phase == 2) && mem_resp_valid;
        chk("ifu_resp_valid", 64'(ifu_resp_valid), 64'(exp_resp && !cur.who));
        chk("lsu_resp_valid", 64'(lsu_resp_valid), 64'(exp_resp && cur.who));
        if (exp_resp) begin
          if (exp_q.size() == 0) begin
            chk("resp_queue_empty", 64'(0), 64'(1));
          end else begin
            e = exp_q.pop_front();
            if (!e.wen) chk("resp_rdata", 64'(e.who ? lsu_rdata : ifu_rdata), 64'(e.data));
          end
        end
        if (exp_acc) begin
          m_last    = exp_who;
          cur.who   = exp_who;
          cur.wen   = exp_who ? lsu_wen : 1'b0;
          cur.addr  = exp_who ? lsu_addr : ifu_addr;
          cur.wdata = (exp_who && 1'b1) ? lsu_wdata : 32'h0;
          cur.wmask = exp_who ? lsu_wmask : 4'h0;
          cur.data  = model_rd(cur.addr);
          if (cur.wen) model_mem[cur.addr] = merge(model_rd(cur.addr), cur.wdata, cur.wmask);
          exp_q.push_back(cur);
          m_phase = 1;
          if (exp_who) acc_lsu = 1'b1; else acc_ifu = 1'b1;
        end else if (m_phase == 1 && mem_req_ready) begin
          m_phase  = 2;
          hs_seen  = 1'b1;
          hs_wen   = mem_wen;
          hs_addr  = mem_addr;
          hs_wdata = mem_wdata;
          hs_wmask = mem_wmask;
        end else if (exp_resp) begin
          m_phase = 0;
        end
      end
    end
  end

  // ---------------- directed transaction helper ----------------
  // Called right after cycle-0 inputs are driven; memory answers in one cycle.
  task automatic txn(input string nm, input bit who, input logic [31:0] rd, input bit drop);
    logic [31:0] ea, ewd;
    logic        ew;
    logic [3:0]  em;
    ea  = who ? lsu_addr : ifu_addr;
    ew  = who ? lsu_wen : 1'b0;
    ewd = who ? lsu_wdata : 32'h0;
    em  = who ? lsu_wmask : 4'h0;
    #6;
    chk({nm, "_ready_win"}, 64'(who ? lsu_req_ready : ifu_req_ready), 64'(1));
    chk({nm, "_ready_lose"}, 64'(who ? ifu_req_ready : lsu_req_ready), 64'(0));
    chk({nm, "_idle_memv"}, 64'(mem_req_valid), 64'(0));
    cyc();
    if (drop) begin
      if (who) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    end
    mem_req_ready = 1'b1;
    #6;
    chk({nm, "_memv"}, 64'(mem_req_valid), 64'(1));
    chk({nm, "_addr"}, 64'(mem_addr), 64'(ea));
    chk({nm, "_wen"}, 64'(mem_wen), 64'(ew));
    chk({nm, "_wdata"}, 64'(mem_wdata), 64'(ewd));
    chk({nm, "_wmask"}, 64'(mem_wmask), 64'(em));
    cyc();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    #6;
    chk({nm, "_resp_own"}, 64'(who ? lsu_resp_valid : ifu_resp_valid), 64'(1));
    chk({nm, "_resp_other"}, 64'(who ? ifu_resp_valid : lsu_resp_valid), 64'(0));
    chk({nm, "_rdata"}, 64'(who ? lsu_rdata : ifu_rdata), 64'(rd));
    chk({nm, "_wait_rdy"}, 64'({ifu_req_ready, lsu_req_ready, mem_req_valid}), 64'(0));
    cyc();
    mem_resp_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit drained;
    acc_ifu = 1'b0; acc_lsu = 1'b0; hs_seen = 1'b0;
    m_phase = 0; m_last = 1'b1;
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;

    // reset: two cycles with both masters requesting
    cyc();
    cyc();
    #6;
    chk("rst_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
    chk("rst_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
    chk("rst_memv", 64'(mem_req_valid), 64'(0));
    chk("rst_fields", 64'({mem_addr, mem_wen, mem_wmask}), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));

    // contention from reset: I, L, I, L
    cyc();
    rst = 1'b0;
    txn("c0", 1'b0, 32'h1111_0000, 1'b0);
    txn("c1", 1'b1, 32'h2222_0000, 1'b0);
    txn("c2", 1'b0, 32'h3333_0000, 1'b0);
    txn("c3", 1'b1, 32'h4444_0000, 1'b0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // store passthrough, single response pulse
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    txn("st", 1'b1, 32'h0000_0000, 1'b1);
    #6;
    chk("st_pulse_once", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));

    // single IFU fetch
    cyc();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    txn("if", 1'b0, 32'h0010_0073, 1'b1);

    // backpressure with a stray response in REQ and the IFU waiting
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0040;
    #6;
    chk("bp_accept", 64'(lsu_req_ready), 64'(1));
    cyc();
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      mem_resp_valid = (i == 2);
      mem_rdata      = 32'h1234_5678;
      #6;
      chk("bp_memv", 64'(mem_req_valid), 64'(1));
      chk("bp_addr", 64'(mem_addr), 64'(32'h8000_0040));
      chk("bp_no_grant", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
      chk("bp_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
    end
    cyc();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    #6;
    chk("bp_hs_memv", 64'(mem_req_valid), 64'(1));
    cyc();
    mem_req_ready = 1'b0;
    #6;
    chk("bp_wait_quiet", 64'({mem_req_valid, ifu_resp_valid, lsu_resp_valid}), 64'(0));
    cyc();
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0001;
    #6;
    chk("bp_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(2'b01));
    chk("bp_rdata", 64'(lsu_rdata), 64'(32'hCAFE_0001));

    // IFU waiting through all that is now granted; then reset mid-WAIT
    cyc();
    mem_resp_valid = 1'b0;
    #6;
    chk("post_bp_ifu", 64'(ifu_req_ready), 64'(1));
    cyc();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    #6;
    chk("rw_memv", 64'(mem_req_valid), 64'(1));
    cyc();
    mem_req_ready = 1'b0; rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #6;
    chk("rw_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
    cyc();
    rst = 1'b0; mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
    #6;
    chk("rw_idle_ifu_first", 64'({ifu_req_ready, lsu_req_ready}), 64'(2'b10));
    chk("rw_idle_memv", 64'(mem_req_valid), 64'(0));

    // randomized traffic against the reference model
    cyc();
    rst = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    cyc();
    cyc();
    m_phase = 0; m_last = 1'b1; exp_q.delete();
    acc_ifu = 1'b0; acc_lsu = 1'b0; hs_seen = 1'b0;
    rst = 1'b0; auto_en = 1'b1; gen_new = 1'b1;
    repeat (3000) @(posedge clk);
    gen_new = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 300 && !drained; i++) begin
      @(negedge clk);
      #3;
      drained = (m_phase == 0) && !ifu_req_valid && !lsu_req_valid;
    end
    chk("drain_timeout", 64'(drained), 64'(1));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    auto_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
